// File: rtl/rect_fill_pkg.sv
// rect_fill_pkg: shared definitions for the rectangle fill engine.
//   - default screen geometry and bus widths
//   - FSM state enumeration used by rect_fill
package rect_fill_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_X_W      = 8;
  localparam int DEF_Y_W      = 7;
  localparam int DEF_COLOR_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rect_fill_raster_counter.sv
// raster_counter: x/y scan counters for a rectangular region.
//   clk, resetn          clock, synchronous active-low reset
//   load                 capture start corner and inclusive end bounds
//   x_start, y_start     top-left corner
//   x_last, y_last       inclusive bottom-right corner (already clipped)
//   adv                  step to the next pixel in raster order
//   x, y                 current pixel position
//   last                 current pixel is the final one of the region
module raster_counter
  import rect_fill_pkg::*;
#(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load,
  input  logic [X_W-1:0] x_start,
  input  logic [Y_W-1:0] y_start,
  input  logic [X_W-1:0] x_last,
  input  logic [Y_W-1:0] y_last,
  input  logic           adv,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_lo;
  logic [X_W-1:0] x_hi;
  logic [Y_W-1:0] y_hi;

  assign last = (x == x_hi) && (y == y_hi);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x    <= '0;
      y    <= '0;
      x_lo <= '0;
      x_hi <= '0;
      y_hi <= '0;
    end else if (load) begin
      x    <= x_start;
      y    <= y_start;
      x_lo <= x_start;
      x_hi <= x_last;
      y_hi <= y_last;
    end else if (adv && !last) begin
      // Position is left parked on the final pixel once the region is done.
      if (x == x_hi) begin
        x <= x_lo;
        y <= y + Y_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/rect_fill.sv
// rect_fill: fills a clipped rectangle with one colour, emitting one pixel
// per accepted handshake toward a VGA adapter.
//   clk, resetn                clock, synchronous active-low reset
//   start                      request a fill (sampled only in IDLE)
//   x0, y0, w, h, color        rectangle corner, size and fill colour
//   pix_ready                  downstream accepts the presented pixel
//   plot, x_out, y_out,        presented pixel; transfer when plot & pix_ready
//   color_out
//   busy                       fill in progress
//   done                       one-cycle pulse at request completion
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// FILL  | presenting pixels, counters step on each transfer
// DONE  | one-cycle completion pulse, then back to IDLE
module rect_fill
  import rect_fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOR_W  = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     w,
  input  logic [Y_W-1:0]     h,
  input  logic [COLOR_W-1:0] color,
  input  logic               pix_ready,
  output logic               plot,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               busy,
  output logic               done
);

  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [X_W:0] X_MAX = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);
  localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - 1);

  state_t         state;
  logic [X_W:0]   x_sum;
  logic [Y_W:0]   y_sum;
  logic [X_W-1:0] x_end_c;
  logic [Y_W-1:0] y_end_c;
  logic           region_empty;
  logic           load;
  logic           xfer;
  logic           adv;
  logic           cnt_last;

  // One extra bit so that corner + size cannot wrap before clipping.
  assign x_sum = {1'b0, x0} + {1'b0, w} - (X_W+1)'(1);
  assign y_sum = {1'b0, y0} + {1'b0, h} - (Y_W+1)'(1);

  assign x_end_c = (x_sum > X_MAX) ? X_MAX[X_W-1:0] : x_sum[X_W-1:0];
  assign y_end_c = (y_sum > Y_MAX) ? Y_MAX[Y_W-1:0] : y_sum[Y_W-1:0];

  // A zero size makes the sums underflow, but the region is empty then anyway.
  assign region_empty = (w == '0) || (h == '0) ||
                        ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);

  assign load = (state == ST_IDLE) && start && !region_empty;
  assign xfer = plot && pix_ready;
  assign adv  = (state == ST_FILL) && xfer;

  raster_counter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_raster (
    .clk     (clk),
    .resetn  (resetn),
    .load    (load),
    .x_start (x0),
    .y_start (y0),
    .x_last  (x_end_c),
    .y_last  (y_end_c),
    .adv     (adv),
    .x       (x_out),
    .y       (y_out),
    .last    (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      plot      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      color_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (region_empty) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_FILL;
              plot      <= 1'b1;
              busy      <= 1'b1;
              color_out <= color;
            end
          end
        end
        ST_FILL: begin
          if (xfer && cnt_last) begin
            state <= ST_DONE;
            plot  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          plot  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 Parameter SCREEN_W, default 160, visible columns.
REQ-002 Parameter SCREEN_H, default 120, visible rows.
REQ-003 Parameter X_W, default 8, x coordinate/width bus width.
REQ-004 Parameter Y_W, default 7, y coordinate/height bus width.
REQ-005 Parameter COLOR_W, default 3, pixel colour width.
REQ-006 Clock and reset: clk, rising edge; reset resetn, synchronous, active-low.
REQ-007 clk  input  1  system clock.
REQ-008 resetn  input  1  synchronous active-low reset.
REQ-009 start  input  1  one-cycle request to begin a fill; sampled only in IDLE.
REQ-010 x0  input  X_W  rectangle left column.
REQ-011 y0  input  Y_W  rectangle top row.
REQ-012 w  input  X_W  rectangle width in pixels.
REQ-013 h  input  Y_W  rectangle height in pixels.
REQ-014 color  input  COLOR_W  fill colour (all-zero gives erase).
REQ-015 pix_ready  input  1  downstream VGA-adapter accepts pixel this cycle.
REQ-016 plot  output  1  pixel valid; transfer occurs when plot and pix_ready both 1.
REQ-017 x_out  output  X_W  pixel column.
REQ-018 y_out  output  Y_W  pixel row.
REQ-019 color_out  output  COLOR_W  pixel colour.
REQ-020 busy  output  1  high in FILL.
REQ-021 done  output  1  one-cycle pulse when a request completes.

Function
REQ-022 States IDLE, FILL, DONE; IDLE->FILL on start with non-empty clipped region; IDLE->DONE on start with empty region; FILL->DONE on transfer of last pixel; DONE->IDLE unconditionally after one cycle.
REQ-023 On accepted start, x0/y0/color and clipped bounds registered; later input changes have no effect on the running fill.
REQ-024 Clipping: x_end = min(x0+w-1, SCREEN_W-1), y_end = min(y0+h-1, SCREEN_H-1); sums computed at X_W+1 / Y_W+1 bits, no wrap.
REQ-025 Region empty when w==0, h==0, x0>=SCREEN_W or y0>=SCREEN_H; no plot issued, done pulses one cycle after start.
REQ-026 Raster order: x increments inner from x0 to x_end, then x returns to x0 and y increments, ending at (x_end, y_end).
REQ-027 First pixel (x0,y0) presented with plot=1 the cycle after start (latency 1).
REQ-028 Counters advance only on transfer; with pix_ready=0, plot, x_out, y_out, color_out hold stable.
REQ-029 One pixel per cycle at sustained pix_ready=1; pixel count = (x_end-x0+1)*(y_end-y0+1).
REQ-030 start during FILL or DONE ignored, not queued.
REQ-031 done asserted exactly in DONE state; busy exactly in FILL; plot only in FILL.

Reset
REQ-032 resetn=0 at a clock edge forces IDLE, plot=0, busy=0, done=0, x_out=0, y_out=0, color_out=0, regardless of state.
REQ-033 Reset mid-fill abandons the fill with no done pulse; next start after reset released begins fresh.

Structure
REQ-034 Shared package holds state enumeration and default SCREEN_W/SCREEN_H/X_W/Y_W/COLOR_W constants.
REQ-035 One sub-module, raster_counter: x/y counters with load, advance-on-enable, bounds, last-pixel flag.

Verification
REQ-036 Full-screen erase: x0=0,y0=0,w=160,h=120,color=0, pix_ready=1 -> 19200 plots, last (159,119), done 19201 cycles after start.
REQ-037 Small box: x0=10,y0=5,w=3,h=2,color=5 -> plots (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) colour 5, then done.
REQ-038 Clip: x0=158,y0=118,w=5,h=5 -> 4 plots (158,118),(159,118),(158,119),(159,119), then done.
REQ-039 Empty: w=0 or x0=200 -> no plot, done one cycle after start.
REQ-040 Backpressure: box 2x1, pix_ready low 3 cycles on first pixel -> (x0,y0) held 4 cycles, no pixel skipped or duplicated.
REQ-041 Reset mid-fill at pixel 50 of full-screen -> outputs 0 next cycle, no done; new start of 1x1 box yields one plot and done.
